// File: rtl/receive.sv
// UART receiver: 2-flop rxd synchronizer, 16x oversampled frame FSM, single-byte holding register.
// Optional stop-bit checking is enabled by defining RECEIVE_FRAME_CHECK_EN.
module receive (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       receive_baud16,
  input  logic       rxd,
  input  logic       receive_read_en,
  output logic [7:0] receive_read_line,
  output logic       rda,
  output logic       receive_frame_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic       rx_meta_q, rxs_q;
  logic [1:0] state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] line_q, line_d;
  logic       rda_q, rda_d;
  logic       stop_sample;
  logic       tick_last;

  assign tick_last = receive_baud16 && (tick_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    if (receive_baud16) tick_d = tick_q + 4'd1;
    case (state_q)
      StIdle: begin
        tick_d = 4'd0;
        bit_d  = 3'd0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        // Mid start bit: a high line here is a glitch, not a frame.
        if (receive_baud16 && (tick_q == 4'd7)) begin
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick_last) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick_last) begin
          stop_sample = 1'b1;
          tick_d      = 4'd0;
          bit_d       = 3'd0;
          state_d     = StIdle;
        end
      end
      default: begin
        tick_d  = 4'd0;
        bit_d   = 3'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Accept is evaluated after the read so a coincident accept keeps rda set.
  always_comb begin
    line_d = line_q;
    rda_d  = rda_q;
    if (receive_read_en) rda_d = 1'b0;
`ifdef RECEIVE_FRAME_CHECK_EN
    if (stop_sample && rxs_q) begin
`else
    if (stop_sample) begin
`endif
      line_d = shift_q;
      rda_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= StIdle;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      line_q    <= 8'h00;
      rda_q     <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      rda_q     <= rda_d;
    end
  end

`ifdef RECEIVE_FRAME_CHECK_EN
  logic ferr_q, ferr_d;

  // A new error outranks a coincident read clear.
  always_comb begin
    ferr_d = ferr_q;
    if (receive_read_en) ferr_d = 1'b0;
    if (stop_sample && !rxs_q) ferr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ferr_q <= 1'b0;
    else        ferr_q <= ferr_d;
  end

  assign receive_frame_err = ferr_q;
`else
  assign receive_frame_err = 1'b0;
`endif

  assign receive_read_line = line_q;
  assign rda               = rda_q;

endmodule

// File: tb/tb_receive.sv
// Self-checking bench for receive: table-driven frames plus hand-written corner sequences.
module tb_receive;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       receive_baud16;
  logic       rxd;
  logic       receive_read_en;
  logic [7:0] receive_read_line;
  logic       rda;
  logic       receive_frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         div;
    logic [7:0] exp_line;
    logic       exp_rda;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[4];

  receive u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .receive_baud16    (receive_baud16),
    .rxd               (rxd),
    .receive_read_en   (receive_read_en),
    .receive_read_line (receive_read_line),
    .rda               (rda),
    .receive_frame_err (receive_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd             = 1'b1;
    receive_baud16  = 1'b1;
    receive_read_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    receive_read_en = 1'b1;
    @(negedge clk);
    receive_read_en = 1'b0;
  endtask

  // One frame, 16*div cycles per bit; negedge index i counts from the start-bit drive.
  // read_at pulses receive_read_en at that index; abort_at asserts reset and returns.
  task automatic send(input logic [7:0] data, input logic stop, input int div,
                      input int read_at, input int abort_at);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < 160 * div; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n           = 1'b0;
        rxd             = 1'b1;
        receive_read_en = 1'b0;
        return;
      end
      rxd             = frame[i / (16 * div)];
      receive_baud16  = ((i % div) == 0);
      receive_read_en = (i == read_at);
    end
  endtask

  initial begin
`ifdef RECEIVE_FRAME_CHECK_EN
    vecs[1] = '{data: 8'h55, stop: 1'b0, div: 1, exp_line: 8'hA5, exp_rda: 1'b0, exp_ferr: 1'b1};
`else
    vecs[1] = '{data: 8'h55, stop: 1'b0, div: 1, exp_line: 8'h55, exp_rda: 1'b1, exp_ferr: 1'b0};
`endif
    vecs[0] = '{data: 8'hA5, stop: 1'b1, div: 1, exp_line: 8'hA5, exp_rda: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, div: 2, exp_line: 8'h0F, exp_rda: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h80, stop: 1'b1, div: 3, exp_line: 8'h80, exp_rda: 1'b1, exp_ferr: 1'b0};

    rst_n           = 1'b0;
    rxd             = 1'b1;
    receive_baud16  = 1'b0;
    receive_read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_line", receive_read_line, 8'h00);
    check("reset_rda", {7'd0, rda}, 8'h00);
    check("reset_ferr", {7'd0, receive_frame_err}, 8'h00);
    rst_n = 1'b1;
    idle(10);

    for (int v = 0; v < 4; v++) begin
      send(vecs[v].data, vecs[v].stop, vecs[v].div, -1, -1);
      idle(40);
      check($sformatf("vec%0d_line", v), receive_read_line, vecs[v].exp_line);
      check($sformatf("vec%0d_rda", v), {7'd0, rda}, {7'd0, vecs[v].exp_rda});
      check($sformatf("vec%0d_ferr", v), {7'd0, receive_frame_err}, {7'd0, vecs[v].exp_ferr});
      read_pulse();
      check($sformatf("vec%0d_rda_after_read", v), {7'd0, rda}, 8'h00);
      check($sformatf("vec%0d_ferr_after_read", v), {7'd0, receive_frame_err}, 8'h00);
    end

    // Glitch on the line: 4 low ticks is a false start.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("false_start_rda", {7'd0, rda}, 8'h00);
    check("false_start_line", receive_read_line, 8'h80);
    send(8'h3C, 1'b1, 1, -1, -1);
    idle(20);
    check("after_false_line", receive_read_line, 8'h3C);
    check("after_false_rda", {7'd0, rda}, 8'h01);
    read_pulse();

    // Back-to-back frames with no read: overrun keeps rda high.
    send(8'h01, 1'b1, 1, -1, -1);
    check("b2b_first_line", receive_read_line, 8'h01);
    check("b2b_first_rda", {7'd0, rda}, 8'h01);
    send(8'hFE, 1'b1, 1, -1, -1);
    check("b2b_second_line", receive_read_line, 8'hFE);
    check("b2b_second_rda", {7'd0, rda}, 8'h01);

    // Read lands in the accept cycle (stop sample at edge 155) while rda is already set.
    send(8'h7E, 1'b1, 1, 154, -1);
    check("coinc_line", receive_read_line, 8'h7E);
    check("coinc_rda", {7'd0, rda}, 8'h01);
    read_pulse();
    check("coinc_rda_after_read", {7'd0, rda}, 8'h00);

    // Reset during data bit 4 with a byte pending.
    idle(5);
    send(8'h99, 1'b1, 1, -1, -1);
    idle(5);
    check("pre_reset_rda", {7'd0, rda}, 8'h01);
    send(8'hC3, 1'b1, 1, -1, 88);
    @(negedge clk);
    check("midreset_line", receive_read_line, 8'h00);
    check("midreset_rda", {7'd0, rda}, 8'h00);
    check("midreset_ferr", {7'd0, receive_frame_err}, 8'h00);
    rst_n = 1'b1;
    idle(40);
    check("post_reset_idle_rda", {7'd0, rda}, 8'h00);
    send(8'hC3, 1'b1, 1, -1, -1);
    idle(10);
    check("post_reset_line", receive_read_line, 8'hC3);
    check("post_reset_rda", {7'd0, rda}, 8'h01);
    check("post_reset_ferr", {7'd0, receive_frame_err}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
